// File: rtl/exu_oitf.sv
// Outstanding Instruction Track FIFO for long-pipe instructions.
// Tracks in-flight destination registers in dispatch order, retires the oldest
// entry on long-pipe write-back and flags RAW/WAW hazards for dispatch.
module exu_oitf #(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned PTR_W       = $clog2(DEPTH),
  parameter int unsigned RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // Allocation
  input  logic                   dis_ena,
  output logic                   dis_ready,
  input  logic                   dis_rdwen,
  input  logic [RFIDX_WIDTH-1:0] dis_rdidx,
  output logic [PTR_W-1:0]       dis_ptr,
  // Retirement
  input  logic                   ret_ena,
  output logic [PTR_W-1:0]       ret_ptr,
  output logic                   ret_rdwen,
  output logic [RFIDX_WIDTH-1:0] ret_rdidx,
  output logic                   oitf_empty,
  // Dependency check
  input  logic                   chk_rs1en,
  input  logic [RFIDX_WIDTH-1:0] chk_rs1idx,
  input  logic                   chk_rs2en,
  input  logic [RFIDX_WIDTH-1:0] chk_rs2idx,
  input  logic                   chk_rdwen,
  input  logic [RFIDX_WIDTH-1:0] chk_rdidx,
  output logic                   oitfrd_match_rs1,
  output logic                   oitfrd_match_rs2,
  output logic                   oitfrd_match_rd
);

  localparam logic [PTR_W:0] PtrOne = 1;

  // Pointers carry an extra wrap flag in the MSB to tell full from empty.
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [DEPTH-1:0]       rdwen_q, rdwen_d;
  logic [RFIDX_WIDTH-1:0] rdidx_q [DEPTH];
  logic [RFIDX_WIDTH-1:0] rdidx_d [DEPTH];

  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic             empty, full;
  logic             do_alloc, do_ret;
  logic             hit_rs1, hit_rs2, hit_rd;

  assign wr_idx   = wr_ptr_q[PTR_W-1:0];
  assign rd_idx   = rd_ptr_q[PTR_W-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  // No bypass: a same-cycle retire never frees a slot for a same-cycle allocate.
  assign do_alloc = dis_ena & ~full;
  assign do_ret   = ret_ena & ~empty;

  // Next-state for pointers and entry storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    rdwen_d  = rdwen_q;
    rdidx_d  = rdidx_q;
    if (do_alloc) begin
      vld_d[wr_idx]   = 1'b1;
      // x0 is never a real destination, so it must never raise a hazard.
      rdwen_d[wr_idx] = dis_rdwen & (dis_rdidx != '0);
      rdidx_d[wr_idx] = dis_rdidx;
      wr_ptr_d        = wr_ptr_q + PtrOne;
    end
    if (do_ret) begin
      vld_d[rd_idx] = 1'b0;
      rd_ptr_d      = rd_ptr_q + PtrOne;
    end
  end

  // State registers; reset discards every outstanding entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
      rdwen_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rdidx_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      rdwen_q  <= rdwen_d;
      rdidx_q  <= rdidx_d;
    end
  end

  // Hazard search over registered entries only (retiring entries still match).
  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    hit_rd  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && rdwen_q[i]) begin
        if (rdidx_q[i] == chk_rs1idx) hit_rs1 = 1'b1;
        if (rdidx_q[i] == chk_rs2idx) hit_rs2 = 1'b1;
        if (rdidx_q[i] == chk_rdidx)  hit_rd  = 1'b1;
      end
    end
  end

  // Output decode.
  always_comb begin
    dis_ready        = ~full;
    dis_ptr          = wr_idx;
    ret_ptr          = rd_idx;
    oitf_empty       = empty;
    ret_rdwen        = empty ? 1'b0 : rdwen_q[rd_idx];
    ret_rdidx        = empty ? '0 : rdidx_q[rd_idx];
    oitfrd_match_rs1 = chk_rs1en & hit_rs1;
    oitfrd_match_rs2 = chk_rs2en & hit_rs2;
    oitfrd_match_rd  = chk_rdwen & hit_rd;
  end

endmodule
